// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives 16 pins from the SPI config registers. Each pin is
// off, static-high, or the shared 8-bit PWM waveform. The duty value is
// double-buffered into a shadow register that only reloads at a period
// boundary, so a mid-period write can never produce a runt pulse.
module pwm_peripheral #(
    parameter int CLK_DIV = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    // Prescaler is at least one bit wide so CLK_DIV=1 still elaborates.
    localparam int              PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_prescaler;
    logic [7:0]    r_pwm_cnt;
    logic [7:0]    r_duty_shadow;

    logic          w_tick;
    logic          w_boundary;
    logic          w_pwm_level;
    logic [15:0]   w_en_out;
    logic [15:0]   w_en_pwm;

    assign w_tick      = (r_prescaler == PRE_MAX);
    assign w_boundary  = w_tick && (r_pwm_cnt == 8'hFF);
    // 0xFF is forced fully high so there is no one-step low gap at the end.
    assign w_pwm_level = (r_duty_shadow == 8'hFF) || (r_pwm_cnt < r_duty_shadow);
    assign w_en_out    = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm    = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Prescaler: count 0..CLK_DIV-1, wrap on tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prescaler <= '0;
        end else if (w_tick) begin
            r_prescaler <= '0;
        end else begin
            r_prescaler <= r_prescaler + PW'(1);
        end
    end

    // PWM step counter: advances once per tick, wraps naturally 255->0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= 8'h00;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 8'h01;
        end
    end

    // Shadow duty reload and period_start pulse, both at the period boundary;
    // the pulse is registered so it lines up with pwm_cnt==0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty_shadow <= 8'h00;
            period_start  <= 1'b0;
        end else begin
            period_start <= w_boundary;
            if (w_boundary) begin
                r_duty_shadow <= pwm_duty_cycle;
            end
        end
    end

    // Registered pin drive: enable gates everything, select picks PWM or high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= 16'h0000;
        end else begin
            out <= w_en_out & (~w_en_pwm | {16{w_pwm_level}});
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: directed tests for pwm_peripheral with a period-level
// reference model and a per-cycle compare process.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 13;
  localparam int P       = CLK_DIV * 256;

  logic        clk;
  logic        rst;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  int total = 0;
  int bad   = 0;

  pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: position inside the period comes from the number of
  // clocks since reset; the duty in force is whatever was presented on the
  // clock that ended the previous period.
  int          m_n;
  logic [7:0]  m_shadow;
  logic [15:0] exp_out;
  logic        exp_ps;
  logic        m_valid = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic lvl;
    if (rst) begin
      m_n      = 0;
      m_shadow = 8'h00;
      exp_out  = 16'h0000;
      exp_ps   = 1'b0;
      m_valid  = 1'b1;
    end else begin
      lvl     = (m_shadow == 8'hFF) || (((m_n % P) / CLK_DIV) < int'(m_shadow));
      exp_out = {en_reg_out_15_8, en_reg_out_7_0} &
                (~{en_reg_pwm_15_8, en_reg_pwm_7_0} | {16{lvl}});
      m_n     = m_n + 1;
      exp_ps  = ((m_n % P) == 0);
      if (exp_ps) m_shadow = pwm_duty_cycle;
    end
  end

  // compare process: every cycle outside reset
  always @(negedge clk) begin
    if (m_valid && !rst) begin
      chk("out_cycle", 32'(out), 32'(exp_out));
      chk("ps_cycle", 32'(period_start), 32'(exp_ps));
    end
  end

  // driver tasks
  task automatic set_regs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    en_reg_out_7_0  = eo[7:0];
    en_reg_out_15_8 = eo[15:8];
    en_reg_pwm_7_0  = ep[7:0];
    en_reg_pwm_15_8 = ep[15:8];
    pwm_duty_cycle  = d;
  endtask

  // Wait (bounded) until a negedge where period_start is high.
  task automatic wait_ps();
    int k;
    k = 0;
    while (k < P + 2) begin
      @(negedge clk);
      k++;
      if (period_start) break;
    end
    if (!period_start) begin
      bad++;
      total++;
      $display("FAIL wait_ps: no period_start within %0d clks", P + 2);
    end
  endtask

  // Called on the negedge where period_start is high; observes one full period
  // of out[0] and ends on the next period_start negedge. Optionally writes a
  // new duty on cycle wr_k of the window.
  task automatic measure(output int highs, output int toggles, output int ps_k,
                         output logic [15:0] upper_or,
                         input int wr_k, input logic [7:0] wr_val);
    logic prev;
    highs    = 0;
    toggles  = 0;
    ps_k     = 0;
    upper_or = 16'h0000;
    prev     = out[0];
    for (int k = 1; k <= P; k++) begin
      @(negedge clk);
      if (out[0]) highs++;
      if (out[0] != prev) toggles++;
      prev     = out[0];
      upper_or = upper_or | (out & 16'hFFFE);
      if (period_start && ps_k == 0) ps_k = k;
      if (k == wr_k) pwm_duty_cycle = wr_val;
    end
  endtask

  task automatic period_chk(input string nm, input int exp_high, input int exp_tog,
                            input int wr_k, input logic [7:0] wr_val);
    int h;
    int t;
    int pk;
    logic [15:0] u;
    measure(h, t, pk, u, wr_k, wr_val);
    chk({nm, "_high"}, 32'(h), 32'(exp_high));
    chk({nm, "_low"}, 32'(P - h), 32'(P - exp_high));
    chk({nm, "_toggles"}, 32'(t), 32'(exp_tog));
    chk({nm, "_period"}, 32'(pk), 32'(P));
    chk({nm, "_upper"}, 32'(u), 32'h0);
  endtask

  initial begin
    int ps_cnt;
    logic [15:0] out_or;
    int k;

    rst = 1'b0;
    set_regs(16'h0000, 16'h0000, 8'h00);
    #1 rst = 1'b1;
    #1;
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_ps", 32'(period_start), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: all regs zero for two periods
    ps_cnt = 0;
    out_or = 16'h0000;
    for (int i = 1; i <= 2 * P; i++) begin
      @(negedge clk);
      out_or = out_or | out;
      if (period_start) ps_cnt++;
    end
    chk("t1_out_zero", 32'(out_or), 32'h0);
    chk("t1_ps_count", 32'(ps_cnt), 32'd2);

    // 2: static high on all pins, one clock after the write
    set_regs(16'hFFFF, 16'h0000, 8'h00);
    #1 chk("t2_before_edge", 32'(out), 32'h0);
    @(negedge clk);
    chk("t2_static_high", 32'(out), 32'hFFFF);

    // 3: pin 0 PWM at 0x80, other pins off
    set_regs(16'h0001, 16'h0001, 8'h80);
    wait_ps();
    period_chk("t3_p1", 1664, 2, 0, 8'h00);
    // mid-period write of 0x00 must not disturb this 0x80 period
    period_chk("t3_p2", 1664, 2, 2000, 8'h00);

    // 4: duty 0x00 then 0xFF
    period_chk("t4_zero_a", 0, 0, 0, 8'h00);
    period_chk("t4_zero_b", 0, 0, 2000, 8'hFF);
    period_chk("t4_full_a", P, 1, 0, 8'h00);
    // write 0x40 on the clock of the period boundary: it must be captured
    period_chk("t4_full_b", P, 0, P - 1, 8'h40);

    // 5: 0x40 -> 0xC0 written mid-period
    period_chk("t5_d40", 832, 1, 1000, 8'hC0);
    period_chk("t5_dc0", 2496, 2, 0, 8'h00);

    // 6: reset 100 clocks into a period with all pins PWM
    set_regs(16'hFFFF, 16'hFFFF, 8'h80);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_async_out", 32'(out), 32'h0);
    chk("t6_async_ps", 32'(period_start), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    out_or = 16'h0000;
    k = 0;
    while (k < P + 5) begin
      @(negedge clk);
      k++;
      out_or = out_or | out;
      if (period_start) break;
    end
    chk("t6_first_ps", 32'(k), 32'(P));
    chk("t6_out_zero", 32'(out_or), 32'h0);
    @(negedge clk);
    chk("t6_first_high", 32'(out), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
